video_frame_store: RTL and testbench
====================================

# video_frame_store

Parametrised double-buffered frame store for the video path. Accepts a scaled-down frame of pixels from the SPI stream through a valid/ready handshake and writes it into the back bank. Serves upscaled pixels to the VGA scan-out from the front bank. Banks swap only at a display frame boundary and only when the back bank holds a complete frame, so scan-out never tears; otherwise the front frame is shown again.

## Interface
Parameters:
- SCREEN_WIDTH, 800, visible display width in pixels
- SCREEN_HEIGHT, 600, visible display height in lines
- SCALE_SHIFT, 2, upscale factor is 2^SCALE_SHIFT in each axis (stored frame 200x150 at defaults)
- PIXEL_W, 1, bits per stored pixel

Ports:
- CLK_40  in  1  system/pixel clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- wr_valid  in  1  wr_data valid this cycle
- wr_data  in  PIXEL_W  incoming pixel, raster order, scaled resolution
- wr_ready  out  1  store can accept a pixel; transfer = wr_valid & wr_ready
- rd_x  in  $clog2(SCREEN_WIDTH)  scan-out x position
- rd_y  in  $clog2(SCREEN_HEIGHT)  scan-out y position
- rd_active  in  1  rd_x/rd_y are inside the visible area
- rd_frame_start  in  1  one-cycle pulse at the start of each display frame
- pixel_out  out  PIXEL_W  front-bank pixel for the requested position
- pixel_valid  out  1  pixel_out corresponds to an active request
- front_bank  out  1  index of the bank being displayed
- swap_pulse  out  1  one-cycle pulse in the cycle after a swap
- repeat_count  out  16  frames displayed without a fresh swap; saturating

## Operation
- XW = SCREEN_WIDTH>>SCALE_SHIFT, YH = SCREEN_HEIGHT>>SCALE_SHIFT, DEPTH = XW*YH, AW = $clog2(DEPTH).
- Write FSM:
  - FILL: wr_ready=1. Each transfer writes the back bank at wr_addr, then advances wr_x (wraps at XW-1, increments wr_y). When the transfer is at wr_x=XW-1 and wr_y=YH-1, go to WAIT_SWAP.
  - WAIT_SWAP: wr_ready=0. On rd_frame_start: toggle front_bank, clear wr_x/wr_y, return to FILL.
- Back bank = ~front_bank. Write enable goes only to the back bank.
- Read address = (rd_y>>SCALE_SHIFT)*XW + (rd_x>>SCALE_SHIFT). It is computed in AW bits, with the product in full width before truncation.
- rd_frame_start in FILL does not swap. repeat_count increments, saturating at 16'hFFFF.
- The last write and rd_frame_start in the same cycle: the write completes and the FSM enters WAIT_SWAP. No swap happens and repeat_count increments. The swap occurs at the next rd_frame_start.
- Reset mid-operation: counters clear, FSM goes to FILL, and any partially written frame is abandoned. RAM contents are not cleared.
- Reset values: wr_ready=0 during reset and 1 from the first cycle after; pixel_out=0; pixel_valid=0; front_bank=0; swap_pulse=0; repeat_count=0.

## Timing
- Read pipeline is 2 cycles:
  - Cycle 1: address registered.
  - Cycle 2: synchronous RAM read.
  - rd_x/rd_y/rd_active sampled at cycle N produce pixel_out/pixel_valid at cycle N+2. rd_active is delayed alongside.
- When pixel_valid=0, pixel_out is forced to 0.
- A swap on cycle N sets front_bank at N+1 and swap_pulse at N+1. Reads issued at cycle N+1 or later use the new front bank. Bank select is captured with the address in stage 1.
- wr_ready is a registered function of FSM state. It goes low the cycle after the final transfer.
- Write latency is 1 cycle: data written at cycle N is readable by a read address issued at N+1 or later.

## Configuration
- FRAME_STORE_STATS_EN defined: repeat_count is implemented as specified.
- FRAME_STORE_STATS_EN undefined: repeat_count is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Structure
- Package video_pkg holds:
  - screen constants
  - the write FSM state typedef (FILL, WAIT_SWAP)
  - a function computing the scaled address
- Sub-module fs_bank_ram holds one bank: simple dual-port, DEPTH x PIXEL_W, one write port, one registered read port, both on CLK_40. It is instantiated twice.

## Test plan
- Reset, then 30000 transfers with wr_data = addr[0], then rd_frame_start → swap_pulse 1 cycle later, front_bank=1; read (rd_x=4, rd_y=0) → pixel_out=1 at N+2, (0,0) → 0.
- After the back bank is full, hold wr_valid=1 → wr_ready=0 and no further writes until rd_frame_start.
- rd_frame_start with only 100 pixels written → no swap, front_bank unchanged, repeat_count=1; three such frames → 3.
- Final transfer coincident with rd_frame_start → no swap that cycle; swap at the next rd_frame_start.
- Read (rd_x=799, rd_y=599) → address 29999; rd_x=3 and rd_x=0 return the same pixel (scale 4); rd_active=0 → pixel_valid=0, pixel_out=0.
- Reset asserted after 15000 transfers → wr_ready=0 during reset and 1 after, front_bank=0; the next frame needs 30000 fresh transfers before a swap.

Source files
------------

// File: rtl/video_pkg.sv
// Shared constants, write-FSM state type and scaled-address helper for the
// video frame store.
package video_pkg;

  localparam int unsigned SCREEN_WIDTH_DEF  = 800;
  localparam int unsigned SCREEN_HEIGHT_DEF = 600;
  localparam int unsigned SCALE_SHIFT_DEF   = 2;
  localparam int unsigned PIXEL_W_DEF       = 1;

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } wr_state_e;

  // Linear address of (x>>shift, y>>shift) in a row_w-wide frame, full 32-bit product.
  function automatic logic [31:0] scaled_addr(
    input logic [31:0] x,
    input logic [31:0] y,
    input int unsigned shift,
    input int unsigned row_w
  );
    return (y >> shift) * row_w + (x >> shift);
  endfunction

endpackage

// File: rtl/fs_bank_ram.sv
// One frame bank: simple dual-port RAM with a registered read port.
module fs_bank_ram #(
  parameter int unsigned DEPTH   = 30000,
  parameter int unsigned AW      = 15,
  parameter int unsigned PIXEL_W = 1
) (
  input  logic               CLK_40,
  input  logic               i_wr_en,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [PIXEL_W-1:0] i_wr_data,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [PIXEL_W-1:0] o_rd_data
);

  logic [PIXEL_W-1:0] r_mem [DEPTH];
  logic [PIXEL_W-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge CLK_40) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge CLK_40) begin
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/video_frame_store.sv
// Double-buffered frame store: fills the back bank from the pixel stream and
// serves upscaled pixels from the front bank; banks swap only at a display
// frame start once the back bank holds a complete frame.
// Optional: define FRAME_STORE_STATS_EN to implement the repeat_count counter;
// otherwise repeat_count is tied to zero.
module video_frame_store
  import video_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int unsigned SCALE_SHIFT   = SCALE_SHIFT_DEF,
  parameter int unsigned PIXEL_W       = PIXEL_W_DEF
) (
  input  logic                             CLK_40,
  input  logic                             reset,
  input  logic                             wr_valid,
  input  logic [PIXEL_W-1:0]               wr_data,
  output logic                             wr_ready,
  input  logic [$clog2(SCREEN_WIDTH)-1:0]  rd_x,
  input  logic [$clog2(SCREEN_HEIGHT)-1:0] rd_y,
  input  logic                             rd_active,
  input  logic                             rd_frame_start,
  output logic [PIXEL_W-1:0]               pixel_out,
  output logic                             pixel_valid,
  output logic                             front_bank,
  output logic                             swap_pulse,
  output logic [15:0]                      repeat_count
);

  localparam int unsigned XW    = SCREEN_WIDTH >> SCALE_SHIFT;
  localparam int unsigned YH    = SCREEN_HEIGHT >> SCALE_SHIFT;
  localparam int unsigned DEPTH = XW * YH;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned XCW   = $clog2(XW);
  localparam int unsigned YCW   = $clog2(YH);

  wr_state_e          r_state;
  wr_state_e          w_state_nxt;
  logic               w_xfer;
  logic               w_last;
  logic               w_swap;
  logic               r_wr_ready;
  logic [XCW-1:0]     r_wr_x;
  logic [YCW-1:0]     r_wr_y;
  logic [AW-1:0]      w_wr_addr;
  logic [AW-1:0]      w_rd_addr;
  logic [AW-1:0]      r_rd_addr;
  logic               r_front_bank;
  logic               r_swap_pulse;
  logic               r_rd_bank1;
  logic               r_rd_active1;
  logic               r_rd_bank2;
  logic               r_rd_active2;
  logic [PIXEL_W-1:0] w_rd_data0;
  logic [PIXEL_W-1:0] w_rd_data1;

  assign w_xfer = wr_valid & r_wr_ready;
  assign w_last = w_xfer && (r_wr_x == XCW'(XW - 1)) && (r_wr_y == YCW'(YH - 1));

  assign w_wr_addr = AW'(scaled_addr(32'(r_wr_x), 32'(r_wr_y), 0, XW));
  assign w_rd_addr = AW'(scaled_addr(32'(rd_x), 32'(rd_y), SCALE_SHIFT, XW));

  // Write FSM state register.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write FSM next state; a swap is only possible once the back frame is complete.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_last) begin
          w_state_nxt = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (rd_frame_start) begin
          w_state_nxt = FILL;
          w_swap      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // Handshake ready, bank select and swap indication.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_wr_ready   <= 1'b0;
      r_front_bank <= 1'b0;
      r_swap_pulse <= 1'b0;
    end else begin
      r_wr_ready   <= (w_state_nxt == FILL);
      r_swap_pulse <= w_swap;
      if (w_swap) begin
        r_front_bank <= ~r_front_bank;
      end
    end
  end

  // Raster write position within the scaled frame.
  always_ff @(posedge CLK_40) begin
    if (reset || w_swap) begin
      r_wr_x <= '0;
      r_wr_y <= '0;
    end else if (w_xfer) begin
      if (r_wr_x == XCW'(XW - 1)) begin
        r_wr_x <= '0;
        r_wr_y <= (r_wr_y == YCW'(YH - 1)) ? '0 : r_wr_y + YCW'(1);
      end else begin
        r_wr_x <= r_wr_x + XCW'(1);
      end
    end
  end

  // Read pipeline: address and bank captured together, then aligned with RAM data.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      r_rd_addr    <= '0;
      r_rd_bank1   <= 1'b0;
      r_rd_active1 <= 1'b0;
      r_rd_bank2   <= 1'b0;
      r_rd_active2 <= 1'b0;
    end else begin
      r_rd_addr    <= w_rd_addr;
      r_rd_bank1   <= r_front_bank;
      r_rd_active1 <= rd_active;
      r_rd_bank2   <= r_rd_bank1;
      r_rd_active2 <= r_rd_active1;
    end
  end

  fs_bank_ram #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .PIXEL_W (PIXEL_W)
  ) u_bank0 (
    .CLK_40    (CLK_40),
    .i_wr_en   (w_xfer & r_front_bank),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data0)
  );

  fs_bank_ram #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .PIXEL_W (PIXEL_W)
  ) u_bank1 (
    .CLK_40    (CLK_40),
    .i_wr_en   (w_xfer & ~r_front_bank),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data1)
  );

`ifdef FRAME_STORE_STATS_EN
  logic [15:0] r_repeat_count;

  // Frames shown again without a swap; cleared by a swap, saturating.
  always_ff @(posedge CLK_40) begin
    if (reset || w_swap) begin
      r_repeat_count <= '0;
    end else if (rd_frame_start && (r_repeat_count != 16'hFFFF)) begin
      r_repeat_count <= r_repeat_count + 16'd1;
    end
  end

  assign repeat_count = r_repeat_count;
`else
  assign repeat_count = '0;
`endif

  assign wr_ready    = r_wr_ready;
  assign front_bank  = r_front_bank;
  assign swap_pulse  = r_swap_pulse;
  assign pixel_valid = r_rd_active2;
  assign pixel_out   = r_rd_active2 ? (r_rd_bank2 ? w_rd_data1 : w_rd_data0) : '0;

endmodule

// File: tb/tb_video_frame_store.sv
// Directed bench for video_frame_store at default parameters.
module tb_video_frame_store;

  logic        CLK_40 = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [0:0]  wr_data;
  logic        wr_ready;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic        rd_active;
  logic        rd_frame_start;
  logic [0:0]  pixel_out;
  logic        pixel_valid;
  logic        front_bank;
  logic        swap_pulse;
  logic [15:0] repeat_count;

  int n_total = 0;
  int n_bad   = 0;

`ifdef FRAME_STORE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 CLK_40 = ~CLK_40;

  video_frame_store #(
    .SCREEN_WIDTH  (800),
    .SCREEN_HEIGHT (600),
    .SCALE_SHIFT   (2),
    .PIXEL_W       (1)
  ) dut (
    .CLK_40         (CLK_40),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_active      (rd_active),
    .rd_frame_start (rd_frame_start),
    .pixel_out      (pixel_out),
    .pixel_valid    (pixel_valid),
    .front_bank     (front_bank),
    .swap_pulse     (swap_pulse),
    .repeat_count   (repeat_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rep(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  // Pixel patterns: 0 -> addr bit0, 1 -> constant 1, other -> addr bit1.
  function automatic logic pix(input int mode, input int idx);
    case (mode)
      0:       return idx[0];
      1:       return 1'b1;
      default: return idx[1];
    endcase
  endfunction

  task automatic step();
    @(posedge CLK_40);
    #1;
  endtask

  task automatic write_px(input int n, input int mode, input int base, input bit fs_on_last);
    int   done  = 0;
    int   guard = 0;
    logic rdy;
    while (done < n && guard < n + 50) begin
      rdy            = wr_ready;
      wr_valid       = 1'b1;
      wr_data        = pix(mode, base + done);
      rd_frame_start = fs_on_last && rdy && (done == n - 1);
      step();
      guard++;
      if (rdy) done++;
      rd_frame_start = 1'b0;
    end
    wr_valid = 1'b0;
    chk("wr_cnt", done, n);
  endtask

  task automatic pulse_fs();
    rd_frame_start = 1'b1;
    step();
    rd_frame_start = 1'b0;
  endtask

  task automatic rd_chk(input int x, input int y, input bit act,
                        input logic exp_pix, input logic exp_vld, input string tag);
    rd_x      = 10'(x);
    rd_y      = 10'(y);
    rd_active = act;
    step();
    step();
    chk({tag, "_pix"}, pixel_out, exp_pix);
    chk({tag, "_vld"}, pixel_valid, exp_vld);
    rd_active = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0;
    rd_x = '0; rd_y = '0; rd_active = 1'b0; rd_frame_start = 1'b0;
    step(); step();
    chk("rst_ready", wr_ready, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_swap", swap_pulse, 0);
    chk("rst_pvld", pixel_valid, 0);
    chk("rst_pout", pixel_out, 0);
    chk("rst_rep", repeat_count, 0);
    reset = 1'b0;
    step();
    chk("rdy_after_rst", wr_ready, 1);

    // First full frame into bank 1.
    write_px(30000, 0, 0, 1'b0);
    chk("full_ready", wr_ready, 0);
    chk("full_front", front_bank, 0);
    wr_valid = 1'b1; wr_data = 1'b1;
    repeat (5) step();
    chk("hold_ready", wr_ready, 0);
    wr_valid = 1'b0;

    pulse_fs();
    chk("swp_pulse", swap_pulse, 1);
    chk("swp_front", front_bank, 1);
    chk("swp_rep", repeat_count, rep(0));
    step();
    chk("swp_pulse_end", swap_pulse, 0);
    chk("swp_ready", wr_ready, 1);

    rd_chk(4, 0, 1'b1, 1'b1, 1'b1, "rd_4_0");
    rd_chk(0, 0, 1'b1, 1'b0, 1'b1, "rd_0_0");
    rd_chk(3, 0, 1'b1, 1'b0, 1'b1, "rd_3_0");
    rd_chk(799, 599, 1'b1, 1'b1, 1'b1, "rd_last");
    rd_chk(4, 4, 1'b1, 1'b1, 1'b1, "rd_4_4");
    rd_chk(4, 0, 1'b0, 1'b0, 1'b0, "rd_inact");

    // Partial frame into bank 0, then reset abandons it.
    write_px(15000, 1, 0, 1'b0);
    reset = 1'b1;
    step();
    chk("mr_ready", wr_ready, 0);
    chk("mr_front", front_bank, 0);
    chk("mr_rep", repeat_count, 0);
    step();
    reset = 1'b0;
    step();
    chk("mr_ready_after", wr_ready, 1);
    rd_chk(0, 0, 1'b1, 1'b1, 1'b1, "rd_kept");

    // Incomplete back frame: frame starts only repeat the front frame.
    write_px(100, 2, 0, 1'b0);
    pulse_fs();
    chk("nf1_swap", swap_pulse, 0);
    chk("nf1_front", front_bank, 0);
    chk("nf1_rep", repeat_count, rep(1));
    step();
    pulse_fs();
    chk("nf2_rep", repeat_count, rep(2));
    step();
    pulse_fs();
    chk("nf3_swap", swap_pulse, 0);
    chk("nf3_rep", repeat_count, rep(3));

    // Final transfer coincident with a frame start: swap deferred.
    write_px(29900, 2, 100, 1'b1);
    chk("co_swap", swap_pulse, 0);
    chk("co_front", front_bank, 0);
    chk("co_ready", wr_ready, 0);
    chk("co_rep", repeat_count, rep(4));
    step(); step();
    chk("co_swap_late", swap_pulse, 0);
    pulse_fs();
    chk("sw2_pulse", swap_pulse, 1);
    chk("sw2_front", front_bank, 1);
    chk("sw2_rep", repeat_count, rep(0));

    rd_chk(4, 0, 1'b1, 1'b0, 1'b1, "f2_4_0");
    rd_chk(8, 0, 1'b1, 1'b1, 1'b1, "f2_8_0");
    rd_chk(12, 0, 1'b1, 1'b1, 1'b1, "f2_12_0");
    rd_chk(0, 4, 1'b1, 1'b0, 1'b1, "f2_0_4");
    rd_chk(8, 4, 1'b1, 1'b1, 1'b1, "f2_8_4");
    rd_chk(799, 599, 1'b1, 1'b1, 1'b1, "f2_last");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
